div_fl_param: RTL and testbench
===============================

DIV_FL_PARAM -- requirements
Module: div_fl_param

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of divide value M and period counter.
REQ-002 SHALL have parameter AUX_CH, default 2, number of auxiliary divided-clock channels (1..8).
REQ-003 SHALL have parameter AUX_W, default 8, width of each auxiliary divide value.
REQ-004 SHALL have port base_clk  in  1  single clock; all logic on its rising edge, no gated or derived clocks.
REQ-005 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port div_en  in  1  run request, level.
REQ-007 SHALL have port M  in  CNT_W  integer part of the link period, in base_clk cycles.
REQ-008 SHALL have port N  in  1  half-cycle extension; 1 adds 0.5 cycle to the average period.
REQ-009 SHALL have port aux_div  in  AUX_CH*AUX_W  packed per-channel aux divide values, channel 0 in the LSBs.
REQ-010 SHALL have port doub_flc  out  1  registered link-rate waveform.
REQ-011 SHALL have port flc_tick  out  1  one-cycle pulse on the last cycle of each period.
REQ-012 SHALL have port aux_clk  out  AUX_CH  registered auxiliary divided clocks.
REQ-013 SHALL have port busy  out  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN when div_en=1; RUN->DRAIN when div_en=0; DRAIN->RUN when div_en=1, with no phase disturbance; DRAIN->IDLE on the cycle flc_tick fires.
REQ-016 SHALL capture M and N into shadow registers on IDLE->RUN and on every flc_tick; mid-period changes take effect from the next period.
REQ-017 Effective M SHALL be max(shadow M, 2); M=0 and M=1 are treated as 2.
REQ-018 SHALL toggle a half-step flag on each flc_tick when shadow N=1 (flag cleared on start); period length = M + (N & flag), so periods run M, M+1, M, M+1...
REQ-019 Period counter SHALL run 0..period-1 in RUN and DRAIN, wrap to 0 after period-1, and hold 0 in IDLE.
REQ-020 flc_tick SHALL be 1 exactly when counter = period-1 and state is not IDLE.
REQ-021 doub_flc SHALL be 0 for counter < floor(period/2) and 1 otherwise, registered (one cycle after the counter), and forced 0 in IDLE.
REQ-022 Each aux channel k SHALL count base_clk cycles while busy, wrap at aux_div[k]-1, and toggle aux_clk[k] on wrap (aux period = 2*aux_div[k]).
REQ-023 aux_div[k]=0 SHALL disable channel k: counter and aux_clk[k] held 0.
REQ-024 Aux counters and aux_clk SHALL clear to 0 on entry to IDLE.
REQ-025 Counter arithmetic SHALL be CNT_W+1 bits internally so M=2^CNT_W-1 with N=1 does not overflow.

Reset
REQ-026 When rst=1 at a base_clk edge: state IDLE, all counters 0, shadow M/N 0, half-step flag 0, doub_flc 0, flc_tick 0, aux_clk all 0, busy 0.
REQ-027 rst SHALL override div_en and all events in the same cycle; reset mid-period SHALL abort with no completing tick.

Configuration
REQ-028 Macro DIV_FL_PARAM_RESYNC_EN, when defined, SHALL add input resync (1 bit); resync=1 while busy restarts the period counter, half-step flag and aux counters at 0 on the next cycle, with no flc_tick issued for the aborted period.
REQ-029 Without DIV_FL_PARAM_RESYNC_EN the resync port SHALL not exist and phase SHALL be altered only by reset or IDLE.

Verification
REQ-030 M=8, N=0, div_en held 1 -> flc_tick every 8 cycles; doub_flc 4 low / 4 high.
REQ-031 M=8, N=1 -> tick intervals 8,9,8,9; doub_flc low 4 cycles in each period.
REQ-032 M=8, div_en dropped at counter=3 -> busy stays 1, tick at counter=7, IDLE next cycle, doub_flc 0; re-raise at counter=5 -> no IDLE, uninterrupted ticks.
REQ-033 M changed 8->12 at counter=2 -> current period 8 cycles, next 12; M=1 -> period 2.
REQ-034 aux_div={0,100} -> aux_clk[0] toggles every 100 cycles; aux_clk[1] stays 0.
REQ-035 With DIV_FL_PARAM_RESYNC_EN, M=10, resync at counter=6 -> counter 0 next cycle, no tick, next tick 10 cycles later.

Source files
------------

// File: rtl/div_fl_param.sv
// Fractional link-rate divider: period M, or alternating M/M+1 when N=1, plus AUX_CH
// auxiliary divided clocks. Define DIV_FL_PARAM_RESYNC_EN to add the resync input.
module div_fl_param #(
  parameter int CNT_W  = 10,
  parameter int AUX_CH = 2,
  parameter int AUX_W  = 8
) (
  input  logic                    base_clk,
  input  logic                    rst,
  input  logic                    div_en,
  input  logic [CNT_W-1:0]        M,
  input  logic                    N,
  input  logic [AUX_CH*AUX_W-1:0] aux_div,
`ifdef DIV_FL_PARAM_RESYNC_EN
  input  logic                    resync,
`endif
  output logic                    doub_flc,
  output logic                    flc_tick,
  output logic [AUX_CH-1:0]       aux_clk,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] TWO = (CNT_W+1)'(2);

  state_t           state, state_nx;
  logic [CNT_W:0]   cnt, cnt_nx, m_eff, period;
  logic [CNT_W-1:0] m_sh;
  logic             n_sh, half, half_nx;
  logic             load, tick, doub_nx, restart, aux_hold;

`ifdef DIV_FL_PARAM_RESYNC_EN
  assign restart = resync && (state != IDLE);
`else
  assign restart = 1'b0;
`endif

  // One extra counter bit keeps M = 2^CNT_W-1 plus the half-step from wrapping.
  always_comb begin
    m_eff  = ({1'b0, m_sh} < TWO) ? TWO : {1'b0, m_sh};
    period = m_eff + {{CNT_W{1'b0}}, n_sh & half};
  end

  // Reset and resync both suppress the tick of the period they abort.
  assign tick      = (state != IDLE) && (cnt == period - ONE) && !restart && !rst;
  assign flc_tick  = tick;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (div_en) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN:     if (!div_en) state_nx = DRAIN;
      DRAIN: begin
        if (div_en)    state_nx = RUN;
        else if (tick) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    cnt_nx = (state == IDLE || tick || restart) ? '0 : cnt + ONE;

    half_nx = half;
    if (state == IDLE || restart) half_nx = 1'b0;
    else if (tick && n_sh)        half_nx = ~half;

    // Waveform lags the counter by one cycle and is dropped as soon as we go idle.
    doub_nx = (state_nx != IDLE) && (cnt >= (period >> 1));
    aux_hold = (state == IDLE) || (state_nx == IDLE);
  end

  always_ff @(posedge base_clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      m_sh     <= '0;
      n_sh     <= 1'b0;
      half     <= 1'b0;
      doub_flc <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      half     <= half_nx;
      doub_flc <= doub_nx;
      if (load || tick) begin
        m_sh <= M;
        n_sh <= N;
      end
    end
  end

  for (genvar k = 0; k < AUX_CH; k++) begin : g_aux
    logic [AUX_W-1:0] div_k, acnt;
    logic             clk_k;

    assign div_k      = aux_div[k*AUX_W +: AUX_W];
    assign aux_clk[k] = clk_k;

    // Wrap on >= so a divide value lowered mid-count cannot strand the counter.
    always_ff @(posedge base_clk) begin
      if (rst || aux_hold || div_k == '0) begin
        acnt  <= '0;
        clk_k <= 1'b0;
      end else if (restart) begin
        acnt  <= '0;
      end else if (acnt >= div_k - AUX_W'(1)) begin
        acnt  <= '0;
        clk_k <= ~clk_k;
      end else begin
        acnt  <= acnt + AUX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_fl_param.sv
// Bench for div_fl_param: reset checks, a vector table of period/duty results,
// hand-written drain/reload/reset sequences and a randomized run against a period model.
module tb_div_fl_param;

  localparam int CNT_W  = 10;
  localparam int AUX_CH = 2;
  localparam int AUX_W  = 8;
  localparam int W      = AUX_CH + 2;
  localparam int L      = 400;

  logic                    base_clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    div_en = 1'b0;
  logic [CNT_W-1:0]        M = '0;
  logic                    N = 1'b0;
  logic [AUX_CH*AUX_W-1:0] aux_div = '0;
  logic                    doub_flc, flc_tick, busy;
  logic [AUX_CH-1:0]       aux_clk;
  logic [1:0]              dbg_state;
`ifdef DIV_FL_PARAM_RESYNC_EN
  logic                    resync = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int m;
    bit n;
    int first;
    int i1;
    int i2;
    int low;
  } vec_t;
  vec_t vecs[6];

  div_fl_param #(.CNT_W(CNT_W), .AUX_CH(AUX_CH), .AUX_W(AUX_W)) dut (
    .base_clk (base_clk),
    .rst      (rst),
    .div_en   (div_en),
    .M        (M),
    .N        (N),
    .aux_div  (aux_div),
`ifdef DIV_FL_PARAM_RESYNC_EN
    .resync   (resync),
`endif
    .doub_flc (doub_flc),
    .flc_tick (flc_tick),
    .aux_clk  (aux_clk),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 base_clk = ~base_clk;

  task automatic step();
    @(posedge base_clk);
    @(negedge base_clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    div_en = 1'b0;
    M      = '0;
    N      = 1'b0;
`ifdef DIV_FL_PARAM_RESYNC_EN
    resync = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  // Leaves the bench at sample 0: first RUN cycle, counter at 0.
  task automatic start(input int m, input bit n);
    M      = CNT_W'(m);
    N      = n;
    div_en = 1'b1;
    step();
  endtask

  task automatic measure(input int m, input bit n, output int first, output int i1,
                         output int i2, output int low);
    int t[$];
    bit d[200];
    do_reset();
    start(m, n);
    for (int s = 0; s < 200 && t.size() < 3; s++) begin
      d[s] = doub_flc;
      if (flc_tick) t.push_back(s);
      step();
    end
    if (t.size() < 3) begin
      first = -1; i1 = -1; i2 = -1; low = -1;
    end else begin
      first = t[0];
      i1    = t[1] - t[0];
      i2    = t[2] - t[1];
      low   = 0;
      for (int s = 1; s <= first + 1; s++) if (!d[s]) low++;
    end
  endtask

  // Reference: lay out whole periods back to back, reloading M/N from the input
  // present on each period's last cycle; outputs follow from phase arithmetic.
  task automatic run_random(input int d0, input int d1);
    int ph[L];
    int per[L];
    int m_in[L];
    bit n_in[L];
    int m0, msh, p, s;
    bit n0, nsh, flag;
    logic [W-1:0] exp_v;
    m0 = $urandom_range(0, 20);
    n0 = 1'($urandom_range(0, 1));
    for (int i = 0; i < L; i++) begin
      m_in[i] = (i == 0) ? m0 : m_in[(i == 0) ? 0 : i - 1];
      n_in[i] = (i == 0) ? n0 : n_in[(i == 0) ? 0 : i - 1];
      if ($urandom_range(0, 9) == 0) m_in[i] = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) n_in[i] = 1'($urandom_range(0, 1));
    end
    msh = m0; nsh = n0; flag = 1'b0; s = 0;
    while (s < L) begin
      p = ((msh < 2) ? 2 : msh) + ((nsh && flag) ? 1 : 0);
      for (int o = 0; o < p && s < L; o++) begin
        ph[s]  = o;
        per[s] = p;
        s++;
      end
      if (ph[s-1] == p - 1) begin
        flag = flag ^ nsh;
        msh  = m_in[s-1];
        nsh  = n_in[s-1];
      end
    end
    for (int i = 0; i < L; i++) begin
      exp_v[0] = (ph[i] == per[i] - 1);
      exp_v[1] = 1'b0;
      if (i > 0) exp_v[1] = (ph[i-1] >= per[i-1] / 2);
      exp_v[2] = (d0 != 0) && (((i / ((d0 == 0) ? 1 : d0)) % 2) == 1);
      exp_v[3] = (d1 != 0) && (((i / ((d1 == 0) ? 1 : d1)) % 2) == 1);
      exp_q.push_back(exp_v);
    end

    aux_div = {AUX_W'(d1), AUX_W'(d0)};
    do_reset();
    start(m0, n0);
    for (int i = 0; i < L; i++) begin
      exp_v = exp_q.pop_front();
      check("rand_tick", flc_tick, exp_v[0]);
      check("rand_doub", doub_flc, exp_v[1]);
      check("rand_aux0", aux_clk[0], exp_v[2]);
      check("rand_aux1", aux_clk[1], exp_v[3]);
      check("rand_busy", busy, 1);
      M = CNT_W'(m_in[i]);
      N = n_in[i];
      step();
    end
    aux_div = '0;
  endtask

  initial begin
    int f, a, b, lo;
    int t[$];

    vecs[0] = '{8,  1'b0, 7,  8,  8,  4};
    vecs[1] = '{8,  1'b1, 7,  9,  8,  4};
    vecs[2] = '{1,  1'b0, 1,  2,  2,  1};
    vecs[3] = '{0,  1'b1, 1,  3,  2,  1};
    vecs[4] = '{5,  1'b1, 4,  6,  5,  2};
    vecs[5] = '{13, 1'b0, 12, 13, 13, 6};

    // reset dominates div_en
    rst = 1'b1; div_en = 1'b1; M = CNT_W'(8);
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_tick", flc_tick, 0);
    check("rst_doub", doub_flc, 0);
    check("rst_aux", aux_clk, 0);
    check("rst_state", dbg_state, 0);

    // vector table
    for (int v = 0; v < 6; v++) begin
      measure(vecs[v].m, vecs[v].n, f, a, b, lo);
      check("vec_first", f, vecs[v].first);
      check("vec_int1", a, vecs[v].i1);
      check("vec_int2", b, vecs[v].i2);
      check("vec_low", lo, vecs[v].low);
    end

    // drain: div_en dropped at counter 3
    do_reset();
    start(8, 1'b0);
    for (int s = 0; s <= 9; s++) begin
      check("drain_tick", flc_tick, (s == 7) ? 1 : 0);
      check("drain_busy", busy, (s <= 7) ? 1 : 0);
      if (s >= 5) check("drain_doub", doub_flc, (s <= 7) ? 1 : 0);
      if (s == 8) check("drain_state", dbg_state, 0);
      if (s == 3) div_en = 1'b0;
      step();
    end

    // drop at counter 3, re-raise at counter 5
    do_reset();
    start(8, 1'b0);
    for (int s = 0; s <= 24; s++) begin
      check("reraise_tick", flc_tick, (s % 8 == 7) ? 1 : 0);
      check("reraise_busy", busy, 1);
      if (s == 3) div_en = 1'b0;
      if (s == 5) div_en = 1'b1;
      step();
    end

    // M 8->12 mid-period, then M=1
    do_reset();
    start(8, 1'b0);
    for (int s = 0; s <= 25; s++) begin
      check("reload_tick", flc_tick, (s == 7 || s == 19 || (s > 19 && s % 2 == 1)) ? 1 : 0);
      if (s == 2) M = CNT_W'(12);
      if (s == 8) M = CNT_W'(1);
      step();
    end

    // largest M with half-step
    do_reset();
    start(1023, 1'b1);
    t.delete();
    for (int s = 0; s < 3200 && t.size() < 3; s++) begin
      if (flc_tick) t.push_back(s);
      step();
    end
    check("maxm_ticks", t.size(), 3);
    if (t.size() == 3) begin
      check("maxm_first", t[0], 1022);
      check("maxm_int1", t[1] - t[0], 1024);
      check("maxm_int2", t[2] - t[1], 1023);
    end

    // reset mid-period aborts without a tick
    do_reset();
    start(8, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    rst = 1'b0;
    div_en = 1'b0;
    for (int s = 0; s < 10; s++) begin
      check("midrst_tick", flc_tick, 0);
      step();
    end

`ifdef DIV_FL_PARAM_RESYNC_EN
    do_reset();
    start(10, 1'b0);
    for (int s = 0; s <= 17; s++) begin
      check("resync_tick", flc_tick, (s == 16) ? 1 : 0);
      resync = (s == 6);
      step();
    end
    resync = 1'b0;
`endif

    run_random(100, 0);
    run_random($urandom_range(0, 30), $urandom_range(0, 30));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
